// File: rtl/atm_terminal_arbiter.sv
// Round-robin arbiter sharing one ATM transaction core between N_TERM terminals.
// Define ATM_ARB_TIMEOUT_EN to include the WAIT-state watchdog (timed_out output).
module atm_terminal_arbiter #(
  parameter int N_TERM  = 4,
  parameter int OP_W    = 3,
  parameter int DATA_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_TERM-1:0]        req,
  input  logic [N_TERM*DATA_W-1:0] term_card,
  input  logic [N_TERM*DATA_W-1:0] term_amount,
  input  logic [N_TERM*OP_W-1:0]   term_op,
  output logic [N_TERM-1:0]        resp_valid,
  output logic                     resp_declined,
  output logic                     core_start,
  output logic [DATA_W-1:0]        core_card,
  output logic [DATA_W-1:0]        core_amount,
  output logic [OP_W-1:0]          core_op,
  input  logic                     core_done,
  input  logic                     core_declined,
  output logic                     busy,
  output logic                     timed_out
);

  localparam int IDX_W = $clog2(N_TERM);

  generate
    if (N_TERM < 2 || N_TERM > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("atm_terminal_arbiter: N_TERM must be 2..8 and TIMEOUT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr, ptr_next;
  logic [IDX_W-1:0]  grant, grant_next;
  logic [DATA_W-1:0] card, card_next;
  logic [DATA_W-1:0] amount, amount_next;
  logic [OP_W-1:0]   op, op_next;
  logic              declined, declined_next;

  logic [IDX_W-1:0]  pick;
  logic [IDX_W:0]    probe;
  logic              found;
  logic [OP_W-1:0]   pick_op;

`ifdef ATM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0]  cnt, cnt_next;
`endif

  // Scan from the highest offset down so the closest request to ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    probe = '0;
    for (int k = N_TERM - 1; k >= 0; k--) begin
      probe = {1'b0, ptr} + (IDX_W+1)'(k);
      if (probe >= (IDX_W+1)'(N_TERM)) begin
        probe = probe - (IDX_W+1)'(N_TERM);
      end
      if (req[probe[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = probe[IDX_W-1:0];
      end
    end
  end

  assign pick_op = term_op[pick*OP_W +: OP_W];

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    grant_next    = grant;
    card_next     = card;
    amount_next   = amount;
    op_next       = op;
    declined_next = declined;
`ifdef ATM_ARB_TIMEOUT_EN
    cnt_next      = cnt;
`endif
    core_start    = 1'b0;
    resp_valid    = '0;
    resp_declined = 1'b0;
    timed_out     = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_next  = pick;
          card_next   = term_card[pick*DATA_W +: DATA_W];
          amount_next = term_amount[pick*DATA_W +: DATA_W];
          op_next     = pick_op;
          // Opcodes 0 and all-ones are reserved; refuse without touching the core.
          if (pick_op == '0 || pick_op == '1) begin
            declined_next = 1'b1;
            state_next    = RESPOND;
          end else begin
            declined_next = 1'b0;
            state_next    = ISSUE;
          end
        end
      end
      ISSUE: begin
        core_start = 1'b1;
`ifdef ATM_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
        state_next = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          declined_next = core_declined;
          state_next    = RESPOND;
        end
`ifdef ATM_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          declined_next = 1'b1;
          timed_out     = 1'b1;
          state_next    = RESPOND;
        end else begin
          cnt_next = cnt + 1'b1;
        end
`endif
      end
      RESPOND: begin
        resp_valid[grant] = 1'b1;
        resp_declined     = declined;
        ptr_next          = (grant == IDX_W'(N_TERM - 1)) ? '0 : grant + 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      card     <= '0;
      amount   <= '0;
      op       <= '0;
      declined <= 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      grant    <= grant_next;
      card     <= card_next;
      amount   <= amount_next;
      op       <= op_next;
      declined <= declined_next;
`ifdef ATM_ARB_TIMEOUT_EN
      cnt      <= cnt_next;
`endif
    end
  end

  assign core_card   = card;
  assign core_amount = amount;
  assign core_op     = op;
  assign busy        = (state != IDLE);

endmodule
